// File: rtl/calculadora_pkg.sv
// rtl/calculadora_pkg.sv - shared calculator types: FSM states, key codes, keypad map
package calculadora_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } estado_t;

  localparam logic [3:0] KEY_SUMA   = 4'hA;
  localparam logic [3:0] KEY_RESTA  = 4'hB;
  localparam logic [3:0] KEY_MULT   = 4'hC;
  localparam logic [3:0] KEY_DIV    = 4'hD;
  localparam logic [3:0] KEY_BORRAR = 4'hE;
  localparam logic [3:0] KEY_IGUAL  = 4'hF;

  // Physical keypad layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
    logic [3:0] codigo;
    case ({fila, col})
      4'd0:    codigo = 4'h1;
      4'd1:    codigo = 4'h2;
      4'd2:    codigo = 4'h3;
      4'd3:    codigo = KEY_SUMA;
      4'd4:    codigo = 4'h4;
      4'd5:    codigo = 4'h5;
      4'd6:    codigo = 4'h6;
      4'd7:    codigo = KEY_RESTA;
      4'd8:    codigo = 4'h7;
      4'd9:    codigo = 4'h8;
      4'd10:   codigo = 4'h9;
      4'd11:   codigo = KEY_MULT;
      4'd12:   codigo = KEY_BORRAR;
      4'd13:   codigo = 4'h0;
      4'd14:   codigo = KEY_IGUAL;
      default: codigo = KEY_DIV;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// rtl/divisor_tick.sv - free-running one-cycle tick every DIV clocks
module divisor_tick #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == CNT_MAX)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/lector_teclado.sv
// rtl/lector_teclado.sv - 4x4 keypad scanner with debounce and per-class key strobes
module lector_teclado #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       nuevo_numero,
  output logic       operando_en,
  output logic       igual_en,
  output logic       borrar_en
);
  import calculadora_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_TICKS - 1);

  logic          tick;
  logic [3:0]    row_meta, row_sync;
  estado_t       state_q, state_d;
  logic [1:0]    col_q, col_d, row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic [1:0]    fila_baja;

  divisor_tick #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Rows idle high, so the synchronizer resets to "no key".
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  always_comb begin
    fila_baja = 2'd3;
    if (!row_sync[0])      fila_baja = 2'd0;
    else if (!row_sync[1]) fila_baja = 2'd1;
    else if (!row_sync[2]) fila_baja = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      key_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (row_sync != 4'hF) begin
            row_d   = fila_baja;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!row_sync[row_q]) begin
            if (cnt_q == CNT_FIN) begin
              // key_code is loaded here so it is valid alongside the strobe.
              cnt_d   = '0;
              key_d   = codigo_tecla(row_q, col_q);
              state_d = EMIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (tick) begin
          if (row_sync == 4'hF) begin
            if (cnt_q == CNT_FIN) begin
              cnt_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    nuevo_numero = 1'b0;
    operando_en  = 1'b0;
    igual_en     = 1'b0;
    borrar_en    = 1'b0;
    if (state_q == EMIT) begin
      if (key_q <= 4'h9)            nuevo_numero = 1'b1;
      else if (key_q == KEY_IGUAL)  igual_en     = 1'b1;
      else if (key_q == KEY_BORRAR) borrar_en    = 1'b1;
      else                          operando_en  = 1'b1;
    end
  end

  assign col_out  = ~(4'b0001 << col_q);
  assign key_code = key_q;

endmodule
